// File: rtl/procyon_mhq_fill_if.sv
// Signal bundle between the MHQ fill engine and its neighbours (MHQ head, CCU, LSU/dcache fill port).
// master: the fill engine side; slave: the environment that feeds it and consumes its fills.
interface procyon_mhq_fill_if #(
    parameter int OPTN_ADDR_WIDTH   = 32,
    parameter int OPTN_MHQ_DEPTH    = 4,
    parameter int OPTN_DC_LINE_SIZE = 32
);
    localparam int MHQ_IDX_WIDTH   = (OPTN_MHQ_DEPTH == 1) ? 1 : $clog2(OPTN_MHQ_DEPTH);
    localparam int DC_LINE_WIDTH   = OPTN_DC_LINE_SIZE * 8;
    localparam int DC_OFFSET_WIDTH = $clog2(OPTN_DC_LINE_SIZE);

    logic                                       i_mhq_head_valid;
    logic [OPTN_ADDR_WIDTH-1:DC_OFFSET_WIDTH]   i_mhq_head_addr;
    logic [DC_LINE_WIDTH-1:0]                   i_mhq_head_data;
    logic [OPTN_DC_LINE_SIZE-1:0]               i_mhq_head_byte_select;
    logic [MHQ_IDX_WIDTH-1:0]                   o_mhq_head_ptr;
    logic                                       o_mhq_dequeue;
    logic                                       o_ccu_req;
    logic [OPTN_ADDR_WIDTH-1:DC_OFFSET_WIDTH]   o_ccu_addr;
    logic                                       i_ccu_done;
    logic [DC_LINE_WIDTH-1:0]                   i_ccu_data;
    logic                                       o_mhq_completing;
    logic [OPTN_ADDR_WIDTH-1:DC_OFFSET_WIDTH]   o_mhq_completing_addr;
    logic                                       o_mhq_filling;
    logic [OPTN_ADDR_WIDTH-1:DC_OFFSET_WIDTH]   o_mhq_filling_addr;
    logic                                       o_mhq_fill_en;
    logic [MHQ_IDX_WIDTH-1:0]                   o_mhq_fill_tag;
    logic                                       o_mhq_fill_dirty;
    logic [OPTN_ADDR_WIDTH-1:DC_OFFSET_WIDTH]   o_mhq_fill_addr;
    logic [DC_LINE_WIDTH-1:0]                   o_mhq_fill_data;

    modport master (
        input  i_mhq_head_valid, i_mhq_head_addr, i_mhq_head_data, i_mhq_head_byte_select,
        input  i_ccu_done, i_ccu_data,
        output o_mhq_head_ptr, o_mhq_dequeue, o_ccu_req, o_ccu_addr,
        output o_mhq_completing, o_mhq_completing_addr, o_mhq_filling, o_mhq_filling_addr,
        output o_mhq_fill_en, o_mhq_fill_tag, o_mhq_fill_dirty, o_mhq_fill_addr, o_mhq_fill_data
    );

    modport slave (
        output i_mhq_head_valid, i_mhq_head_addr, i_mhq_head_data, i_mhq_head_byte_select,
        output i_ccu_done, i_ccu_data,
        input  o_mhq_head_ptr, o_mhq_dequeue, o_ccu_req, o_ccu_addr,
        input  o_mhq_completing, o_mhq_completing_addr, o_mhq_filling, o_mhq_filling_addr,
        input  o_mhq_fill_en, o_mhq_fill_tag, o_mhq_fill_dirty, o_mhq_fill_addr, o_mhq_fill_data
    );
endinterface

// File: rtl/procyon_mhq_fill.sv
// MHQ fill engine: fetches the head miss from the CCU, merges pending store bytes, fills and dequeues.
// Define PCYN_MHQ_FULL_LINE_BYPASS_EN to skip the CCU request when the head already holds a full line.
module procyon_mhq_fill #(
    parameter int OPTN_ADDR_WIDTH   = 32,
    parameter int OPTN_MHQ_DEPTH    = 4,
    parameter int OPTN_DC_LINE_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   n_rst,
    procyon_mhq_fill_if.master     mhq
);
    localparam int MHQ_IDX_WIDTH   = (OPTN_MHQ_DEPTH == 1) ? 1 : $clog2(OPTN_MHQ_DEPTH);
    localparam int DC_LINE_WIDTH   = OPTN_DC_LINE_SIZE * 8;
    localparam int DC_OFFSET_WIDTH = $clog2(OPTN_DC_LINE_SIZE);

    typedef logic [OPTN_ADDR_WIDTH-1:DC_OFFSET_WIDTH] line_addr_t;
    typedef enum logic [1:0] {IDLE, REQ, COMPLETE, FILL} state_t;

    state_t                    state_q,    state_d;
    logic [MHQ_IDX_WIDTH-1:0]  head_ptr_q, head_ptr_d;
    logic [MHQ_IDX_WIDTH-1:0]  tag_q,      tag_d;
    line_addr_t                addr_q,     addr_d;
    logic [DC_LINE_WIDTH-1:0]  line_q,     line_d;
    logic                      dirty_q,    dirty_d;
    logic                      fill_en_q,  fill_en_d;
    logic [DC_LINE_WIDTH-1:0]  merged_line;

    // Pending store bytes win over the line returned by the CCU.
    always_comb begin
        merged_line = mhq.i_ccu_data;
        for (int b = 0; b < OPTN_DC_LINE_SIZE; b++) begin
            if (mhq.i_mhq_head_byte_select[b]) merged_line[b*8 +: 8] = mhq.i_mhq_head_data[b*8 +: 8];
        end
    end

    // NOTE: every signal gets its hold value before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        head_ptr_d = head_ptr_q;
        tag_d      = tag_q;
        addr_d     = addr_q;
        line_d     = line_q;
        dirty_d    = dirty_q;
        fill_en_d  = (state_q == FILL);

        case (state_q)
            IDLE: begin
`ifdef PCYN_MHQ_FULL_LINE_BYPASS_EN
                if (mhq.i_mhq_head_valid && (&mhq.i_mhq_head_byte_select)) begin
                    state_d = COMPLETE;
                    line_d  = mhq.i_mhq_head_data;
                    addr_d  = mhq.i_mhq_head_addr;
                    tag_d   = head_ptr_q;
                    dirty_d = 1'b1;
                end else if (mhq.i_mhq_head_valid) begin
                    state_d = REQ;
                end
`else
                if (mhq.i_mhq_head_valid) state_d = REQ;
`endif
            end
            REQ: begin
                if (mhq.i_ccu_done) begin
                    state_d = COMPLETE;
                    line_d  = merged_line;
                    addr_d  = mhq.i_mhq_head_addr;
                    tag_d   = head_ptr_q;
                    dirty_d = |mhq.i_mhq_head_byte_select;
                end
            end
            COMPLETE: state_d = FILL;
            FILL: begin
                state_d    = IDLE;
                head_ptr_d = (head_ptr_q == MHQ_IDX_WIDTH'(OPTN_MHQ_DEPTH - 1)) ? '0 : head_ptr_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            head_ptr_q <= '0;
            fill_en_q  <= 1'b0;
            dirty_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_ptr_q <= head_ptr_d;
            fill_en_q  <= fill_en_d;
            dirty_q    <= dirty_d;
        end
    end

    // NOTE: captured line/address/tag are qualified by the FSM, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        addr_q <= addr_d;
        line_q <= line_d;
    end

    assign mhq.o_mhq_head_ptr        = head_ptr_q;
    assign mhq.o_mhq_dequeue         = (state_q == FILL);
    assign mhq.o_ccu_req             = (state_q == REQ);
    assign mhq.o_ccu_addr            = mhq.i_mhq_head_addr;
    assign mhq.o_mhq_completing      = (state_q == COMPLETE);
    assign mhq.o_mhq_completing_addr = ((state_q == COMPLETE) || (state_q == FILL)) ? addr_q
                                                                                     : mhq.i_mhq_head_addr;
    assign mhq.o_mhq_filling         = (state_q == FILL);
    assign mhq.o_mhq_filling_addr    = addr_q;
    assign mhq.o_mhq_fill_en         = fill_en_q;
    assign mhq.o_mhq_fill_tag        = tag_q;
    assign mhq.o_mhq_fill_dirty      = dirty_q;
    assign mhq.o_mhq_fill_addr       = addr_q;
    assign mhq.o_mhq_fill_data       = line_q;
endmodule
